instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Packs decoded instruction fields (opcode, rs, rt, rd, shamt, funct, immediate, jump target) back into 32-bit MIPS words and streams them into instruction memory through a sequential write port. It sits between the test/program-loading harness and the single-cycle processor's instruction memory. It is the write-side counterpart of the processor's field decoder. A valid/ready input handshake and an auto-incrementing word address let a bench or loader fill memory at one instruction per cycle.

## Interface
- BASE_ADDR, 32'h0040_0000, byte address of the first word written after `start`
- DEPTH, 256, maximum number of words per load run (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse: begin/restart a load run
- stop  input  1  single-cycle pulse: end the run, return to IDLE
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- fmt  input  2  2'b00 R-type, 2'b01 I-type, 2'b10 J-type, 2'b11 reserved
- opcode  input  6  instruction opcode
- rs, rt, rd, shamt  input  5 each  register/shift fields
- funct  input  6  R-type function
- imm  input  16  I-type immediate
- target  input  26  J-type target
- mem_we  output  1  write strobe to instruction memory
- mem_addr  output  32  byte address of the write
- mem_wdata  output  32  packed instruction word
- count  output  $clog2(DEPTH+1)  words written this run
- full  output  1  DEPTH words written
- err  output  1  sticky: reserved fmt seen this run

## Operation
- Reset is synchronous and active-high.
- States:
  - IDLE: reset state.
  - LOAD: accepting bundles.
  - FULL: DEPTH words written.
- Transitions:
  - IDLE/LOAD/FULL + `start` → LOAD, with count=0, full=0, err=0.
  - LOAD + `stop` → IDLE, with count held.
  - LOAD + the accept that makes count reach DEPTH → FULL.
  - FULL leaves only on `start` or `reset`.
- Priority when asserted together in one cycle:
  - `reset` has highest priority, then `start`, then `stop`, then accept.
- Accept condition: `in_valid && in_ready`.
- `in_ready = (state==LOAD) && !start && !stop`. This is combinational from the state register and these two pulses only. It is never derived from `in_valid`.
- Packing:
  - R-type: {opcode, rs, rt, rd, shamt, funct}.
  - I-type: {opcode, rs, rt, imm}.
  - J-type: {opcode, target}.
- Reserved fmt:
  - The bundle is consumed (handshake completes).
  - No memory write occurs and count is unchanged.
  - err is set and stays set until `start` or `reset`.
- Write address: `mem_addr = BASE_ADDR + 4*count`, using the pre-increment count. Arithmetic is 32-bit, wrap modulo 2^32.
- count increments by 1 per valid-format accept and saturates at DEPTH.
- full is set when count equals DEPTH.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 0.
  - mem_we = 0.
  - mem_addr = BASE_ADDR.
  - mem_wdata = 0.
  - count = 0.
  - full = 0.
  - err = 0.
- Latency: an accept at edge N drives mem_we=1 with mem_addr and mem_wdata valid for the cycle after edge N. There is exactly 1 cycle of latency.
- mem_we is 0 in every cycle that does not follow an accept.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Throughput: back-to-back accepts give one write per cycle with no bubbles.
- Full boundary:
  - The DEPTH-th accept updates count, full and state at the same edge.
  - in_ready is 0 in the following cycle.
  - That final write is still issued.
- `start` in the same cycle as `in_valid`: in_ready=0, so no accept. The first accept is possible on the next cycle, at address BASE_ADDR.
- `stop` with a write pending from the previous cycle: the write still completes.
- Reset during a run: any write that would have issued in the next cycle is suppressed. All outputs return to their reset values at that edge.

## Test plan
- Reset, then `start`. Send R-type: opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 6'h20.
  - Required: next cycle mem_we=1, mem_addr=32'h0040_0000, mem_wdata=32'h0022_1820, count=1.
- Back-to-back bundles:
  - I-type: opcode 6'h08, rs 0, rt 8, imm 16'h0005.
  - Then J-type: opcode 6'h02, target 26'h010_0000.
  - Required: writes 32'h2008_0005 at 32'h0040_0000, then 32'h0810_0000 at 32'h0040_0004, on consecutive cycles.
- DEPTH=4, continuous in_valid.
  - Required: 4 writes at 32'h0040_0000 through 32'h0040_000C, full=1, count=4, in_ready=0 from the cycle after the 4th accept, no 5th write.
  - Then `start`: full=0, count=0, next write at 32'h0040_0000.
- Reserved fmt 2'b11 between two R-type bundles.
  - Required: handshake completes, no mem_we pulse for it, err=1, the second R-type lands at 32'h0040_0004.
  - err clears on the next `start`.
- Assert `reset` the cycle after an accept.
  - Required: no mem_we the following cycle, all outputs at reset values, in_ready=0 until `start`.
- Assert `start` and `in_valid` in the same cycle while in LOAD with count=3.
  - Required: no accept that cycle, count=0, the next accepted bundle is written at 32'h0040_0000.

Source files
------------

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_encoder
// Purpose  : Packs decoded MIPS fields into 32-bit words and streams them into
//            instruction memory at consecutive word addresses.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   fmt,
    input  logic [5:0]                   opcode,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  imm,
    input  logic [25:0]                  target,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);

    localparam int            c_cw   = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_max  = c_cw'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_ready;
    logic              w_accept;
    logic              w_reserved;
    logic              w_write;
    logic              w_last;
    logic [31:0]       w_word;
    logic [31:0]       w_addr;

    assign w_ready    = (r_state == S_LOAD) && !start && !stop;
    assign w_accept   = in_valid && w_ready;
    assign w_reserved = (fmt == 2'b11);
    assign w_write    = w_accept && !w_reserved;
    assign w_last     = (r_count == c_last);
    // Byte address of the next word, from the count before this accept.
    assign w_addr     = BASE_ADDR + (32'(r_count) << 2);

    always_comb begin
        w_word = 32'h0;
        case (fmt)
            2'b00:   w_word = {opcode, rs, rt, rd, shamt, funct};
            2'b01:   w_word = {opcode, rs, rt, imm};
            2'b10:   w_word = {opcode, target};
            default: w_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (stop) begin
                        w_state_next = S_IDLE;
                    end else if (w_write && w_last) begin
                        w_state_next = S_FULL;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'h0;
        end else begin
            // A write strobe lasts exactly one cycle after its accept.
            r_mem_we <= w_write;
            if (start) begin
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_reserved) begin
                    r_err <= 1'b1;
                end else begin
                    r_mem_addr  <= w_addr;
                    r_mem_wdata <= w_word;
                    if (r_count != c_max) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_last) begin
                        r_full <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = r_full;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_encoder
// Purpose  : Directed stimulus against a run-level model of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

    localparam logic [31:0] c_base  = 32'h0040_0000;
    localparam int          c_depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = 2'b00;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [$clog2(c_depth+1)-1:0] count;
    logic        full;
    logic        err;

    int errors = 0;
    int checks = 0;

    instruction_encoder #(.BASE_ADDR(c_base), .DEPTH(c_depth)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: mode 0 idle, 1 loading, 2 full.
    int          m_mode = 0;
    int          m_count = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = c_base;
    logic [31:0] m_data = 0;
    bit          go = 0;

    function automatic logic [31:0] pack_word();
        int unsigned w;
        w = 0;
        if (fmt == 2'b00)
            w = opcode * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + shamt * 2**6 + funct;
        else if (fmt == 2'b01)
            w = opcode * 2**26 + rs * 2**21 + rt * 2**16 + imm;
        else
            w = opcode * 2**26 + target;
        return w;
    endfunction

    always @(posedge clk) begin
        go = 1;
        m_we = 0;
        if (reset) begin
            m_mode = 0; m_count = 0; m_err = 0; m_addr = c_base; m_data = 0;
        end else if (start) begin
            m_mode = 1; m_count = 0; m_err = 0;
        end else if (stop && m_mode == 1) begin
            m_mode = 0;
        end else if (in_valid && m_mode == 1) begin
            if (fmt == 2'b11) begin
                m_err = 1;
            end else begin
                m_we   = 1;
                m_addr = c_base + 32'(m_count * 4);
                m_data = pack_word();
                m_count++;
                if (m_count == c_depth) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("in_ready",  32'(in_ready), 32'(m_mode == 1 && !start && !stop));
            chk("mem_we",    32'(mem_we),   32'(m_we));
            chk("mem_addr",  mem_addr,      m_addr);
            chk("mem_wdata", mem_wdata,     m_data);
            chk("count",     32'(count),    32'(m_count));
            chk("full",      32'(full),     32'(m_count == c_depth));
            chk("err",       32'(err),      32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 0; stop = 0; in_valid = 0; reset = 0;
    endtask

    task automatic set_r(input logic [5:0] op, input logic [4:0] a, b, c, sh, input logic [5:0] fn);
        in_valid = 1; fmt = 2'b00; opcode = op; rs = a; rt = b; rd = c; shamt = sh; funct = fn;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] a, b, input logic [15:0] im);
        in_valid = 1; fmt = 2'b01; opcode = op; rs = a; rt = b; imm = im;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] t);
        in_valid = 1; fmt = 2'b10; opcode = op; target = t;
    endtask

    initial begin
        reset = 1; tick();
        reset = 1; tick();
        chk("rst_addr",  mem_addr, 32'h0040_0000);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        // Single R-type
        start = 1; tick();
        set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20); tick();
        chk("r_we",    32'(mem_we), 32'd1);
        chk("r_addr",  mem_addr, 32'h0040_0000);
        chk("r_data",  mem_wdata, 32'h0022_1820);
        chk("r_count", 32'(count), 32'd1);

        // Back-to-back I then J
        start = 1; tick();
        set_i(6'h08, 5'd0, 5'd8, 16'h0005); tick();
        chk("i_data", mem_wdata, 32'h2008_0005);
        chk("i_addr", mem_addr, 32'h0040_0000);
        set_j(6'h02, 26'h010_0000); tick();
        chk("j_we",   32'(mem_we), 32'd1);
        chk("j_data", mem_wdata, 32'h0810_0000);
        chk("j_addr", mem_addr, 32'h0040_0004);

        // Fill to DEPTH with continuous valid, plus one extra
        start = 1; tick();
        for (int i = 0; i < 5; i++) begin
            set_r(6'd0, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 6'h21);
            tick();
            if (i == 3) begin
                chk("full_addr",  mem_addr, 32'h0040_000C);
                chk("full_flag",  32'(full), 32'd1);
                chk("full_count", 32'(count), 32'd4);
                chk("full_ready", 32'(in_ready), 32'd0);
            end
        end
        chk("no_5th_we", 32'(mem_we), 32'd0);
        start = 1; tick();
        chk("restart_full",  32'(full), 32'd0);
        chk("restart_count", 32'(count), 32'd0);
        set_r(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22); tick();
        chk("restart_addr", mem_addr, 32'h0040_0000);

        // Reserved format between two R-types
        start = 1; tick();
        set_r(6'd0, 5'd7, 5'd8, 5'd9, 5'd0, 6'h24); tick();
        in_valid = 1; fmt = 2'b11; tick();
        chk("rsv_we",  32'(mem_we), 32'd0);
        chk("rsv_err", 32'(err), 32'd1);
        set_r(6'd0, 5'd10, 5'd11, 5'd12, 5'd2, 6'h00); tick();
        chk("rsv_addr", mem_addr, 32'h0040_0004);
        start = 1; tick();
        chk("rsv_clear", 32'(err), 32'd0);

        // Stop with a write pending, then valid ignored
        set_r(6'd0, 5'd1, 5'd1, 5'd1, 5'd1, 6'h25); tick();
        stop = 1; in_valid = 1; tick();
        set_r(6'd0, 5'd3, 5'd3, 5'd3, 5'd3, 6'h25); tick();
        chk("stop_count", 32'(count), 32'd1);

        // Reset the cycle after an accept
        start = 1; tick();
        set_r(6'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h2A); tick();
        reset = 1; in_valid = 1; tick();
        chk("rst2_we",   32'(mem_we), 32'd0);
        chk("rst2_addr", mem_addr, 32'h0040_0000);
        chk("rst2_data", mem_wdata, 32'd0);
        in_valid = 1; tick();
        chk("rst2_ready", 32'(in_ready), 32'd0);

        // Start together with valid while count=3
        start = 1; tick();
        for (int i = 0; i < 3; i++) begin
            set_i(6'h0D, 5'(i), 5'(i + 3), 16'(i * 100)); tick();
        end
        chk("pre_count", 32'(count), 32'd3);
        set_i(6'h0D, 5'd9, 5'd9, 16'hBEEF); start = 1; tick();
        chk("st_count", 32'(count), 32'd0);
        set_j(6'h03, 26'h3FF_FFFF); tick();
        chk("st_addr", mem_addr, 32'h0040_0000);
        chk("st_data", mem_wdata, 32'h0FFF_FFFF);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
